// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory boot loader.
// State encodings, frame header and error codes.
package imem_uart_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_FRAME   = 3'd1;
    localparam logic [2:0] ERR_SIZE    = 3'd2;
    localparam logic [2:0] ERR_CHK     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Rounded clock-per-bit divisor, never below 8.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + baud / 2) / baud;
        return (d < 8) ? 8 : d;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchroniser, start-bit glitch filter,
// mid-bit sampling, one-cycle byte / framing-error pulses.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    rx_state_e      st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic           s1_q, s2_q, s3_q;
    logic           vld_q, vld_d;
    logic           fe_q, fe_d;
    logic           fall;
    logic           tick;

    assign fall = s3_q & ~s2_q;
    assign tick = (cnt_q == ((st_q == RX_START) ? HALF : FULL));

    // Synchroniser, edge history and receiver state registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            s3_q  <= 1'b1;
            st_q  <= RX_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
            vld_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            s1_q  <= rx;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            st_q  <= st_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
            vld_q <= vld_d;
            fe_q  <= fe_d;
        end
    end

    // Bit timing: re-check start at half bit, then sample every DIV.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        sh_d  = sh_q;
        vld_d = 1'b0;
        fe_d  = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) st_d = RX_START;
            end
            RX_START: begin
                if (tick) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    sh_d  = {s2_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    vld_d = s2_q;
                    fe_d  = ~s2_q;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    assign byte_o       = sh_q;
    assign byte_valid_o = vld_q;
    assign frame_err_o  = fe_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: UART frame -> instruction memory writes,
// holds the CPU in reset until a checksum-verified image is in.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 10,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              uart_rx_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        err_code_o
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD);
    localparam int TO_CYC = TIMEOUT_BITS * DIV;
    localparam int TO_W   = $clog2(TO_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [15:0] MAX_WORDS = 16'(2 ** ADDR_W);

    logic [7:0]        rx_byte;
    logic              bv;
    logic              fe;

    ld_state_e         st_q, st_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        xor_q, xor_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic              hold_q, hold_d;
    logic              busy;
    logic              last_word;
    logic [15:0]       cnt_full;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .CLK          (CLK),
        .RST          (RST),
        .rx           (uart_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (bv),
        .frame_err_o  (fe)
    );

    assign busy      = (st_q == S_CNT_HI) || (st_q == S_CNT_LO) ||
                       (st_q == S_DATA)   || (st_q == S_CHK);
    assign last_word = ((16'(addr_q) + 16'd1) == cnt_q);
    assign cnt_full  = {cnt_q[15:8], rx_byte};

    // Loader state register; outputs are registered copies.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            addr_q <= '0;
            word_q <= '0;
            xor_q  <= '0;
            bidx_q <= '0;
            to_q   <= '0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            hold_q <= 1'b1;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            word_q <= word_d;
            xor_q  <= xor_d;
            bidx_q <= bidx_d;
            to_q   <= to_d;
            we_q   <= we_d;
            done_q <= done_d;
            err_q  <= err_d;
            code_q <= code_d;
            hold_q <= hold_d;
        end
    end

    // Frame parsing, word assembly, checksum and timeout.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        word_d = word_q;
        xor_d  = xor_q;
        bidx_d = bidx_q;
        to_d   = '0;
        we_d   = 1'b0;
        done_d = done_q;
        err_d  = err_q;
        code_d = code_q;
        hold_d = hold_q;
        if (busy) to_d = to_q + 1'b1;
        if (we_q) begin
            if (last_word) st_d = S_CHK;
            else addr_d = addr_q + 1'b1;
        end
        unique case (st_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bv && rx_byte == HDR_BYTE) begin
                    st_d   = S_CNT_HI;
                    cnt_d  = '0;
                    addr_d = '0;
                    xor_d  = '0;
                    bidx_d = '0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    hold_d = 1'b1;
                end
            end
            S_CNT_HI: begin
                if (bv) begin
                    cnt_d = {rx_byte, 8'h00};
                    st_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (bv) begin
                    cnt_d = cnt_full;
                    if (cnt_full > MAX_WORDS) begin
                        st_d   = S_ERR;
                        err_d  = 1'b1;
                        code_d = ERR_SIZE;
                    end else if (cnt_full == 16'd0) begin
                        st_d = S_CHK;
                    end else begin
                        st_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bv) begin
                    word_d = {word_q[23:0], rx_byte};
                    xor_d  = xor_q ^ rx_byte;
                    bidx_d = bidx_q + 1'b1;
                    we_d   = (bidx_q == 2'd3);
                end
            end
            S_CHK: begin
                if (bv) begin
                    if (rx_byte == xor_q) begin
                        st_d   = S_DONE;
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        st_d   = S_ERR;
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                end
            end
            default: st_d = S_IDLE;
        endcase
        if (busy && fe) begin
            st_d   = S_ERR;
            err_d  = 1'b1;
            code_d = ERR_FRAME;
            we_d   = 1'b0;
        end else if (busy && !bv && to_q == TO_LAST) begin
            st_d   = S_ERR;
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
        end
        if (bv) to_d = '0;
    end

    assign im_we_o    = we_q;
    assign im_addr_o  = addr_q;
    assign im_wdata_o = word_q;
    assign cpu_hold_o = hold_q;
    assign busy_o     = busy;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for the UART boot loader (DIV = 16).
// Each task drives one scenario and checks its own results.
`timescale 1ns/1ps
module tb_imem_uart_loader;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  code;

    int total;
    int bad;
    int wr_n;
    int we_out;
    logic [9:0]  wr_addr [64];
    logic [31:0] wr_data [64];

    imem_uart_loader #(
        .CLK_HZ(1600000),
        .BAUD(100000),
        .ADDR_W(10),
        .TIMEOUT_BITS(64)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .uart_rx_i  (rx),
        .im_we_o    (im_we),
        .im_addr_o  (im_addr),
        .im_wdata_o (im_wdata),
        .cpu_hold_o (hold),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_code_o (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && im_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = im_addr;
                wr_data[wr_n] = im_wdata;
            end
            wr_n = wr_n + 1;
            if (!busy) we_out = we_out + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = fr[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_image(input logic [7:0] chk);
        logic [7:0] f [12];
        f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
              8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, chk};
        for (int i = 0; i < 12; i++) send_byte(f[i], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_two_writes(input int base, input string tag);
        total++;
        if (wr_n - base !== 2) begin
            bad++;
            $display("FAIL %s wr_count got=%0d exp=2", tag, wr_n - base);
        end else begin
            total++;
            if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h12345678) begin
                bad++;
                $display("FAIL %s wr0 got=%0d/%h exp=0/12345678",
                         tag, wr_addr[base], wr_data[base]);
            end
            total++;
            if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h9ABCDEF0) begin
                bad++;
                $display("FAIL %s wr1 got=%0d/%h exp=1/9abcdef0",
                         tag, wr_addr[base+1], wr_data[base+1]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({im_we, im_addr, im_wdata} !== 43'd0) begin
            bad++;
            $display("FAIL reset_wport got=%b/%h/%h exp=0/0/0", im_we, im_addr, im_wdata);
        end
        total++;
        if ({hold, busy, done, err, code} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_status got=%b exp=1000000", {hold, busy, done, err, code});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Checksum of 12 34 56 78 9A BC DE F0 is 0x00.
    task automatic test_good_frame;
        int base;
        base = wr_n;
        send_image(8'h00);
        check_two_writes(base, "good");
        total++;
        if ({done, hold, err, busy, code} !== 7'b1000000) begin
            bad++;
            $display("FAIL good_status got=%b exp=1000000", {done, hold, err, busy, code});
        end
    endtask

    task automatic test_bad_chk;
        int base;
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        total++;
        if ({hold, done, busy} !== 3'b101) begin
            bad++;
            $display("FAIL reload_hold got=%b exp=101", {hold, done, busy});
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h08, 1'b1);
        repeat (4) @(negedge clk);
        check_two_writes(base, "badchk");
        total++;
        if ({err, code, hold, done, busy} !== 7'b1011100) begin
            bad++;
            $display("FAIL badchk_status got=%b exp=1011100", {err, code, hold, done, busy});
        end
    endtask

    task automatic test_oversize;
        int base;
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        total++;
        if (wr_n !== base) begin
            bad++;
            $display("FAIL oversize_writes got=%0d exp=0", wr_n - base);
        end
        total++;
        if ({err, code, busy, hold} !== 6'b101001) begin
            bad++;
            $display("FAIL oversize_status got=%b exp=101001", {err, code, busy, hold});
        end
    endtask

    task automatic test_timeout;
        int n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (900) @(negedge clk);
        total++;
        if ({busy, err} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_early got=%b exp=10", {busy, err});
        end
        n = 0;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (code !== 3'd4 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_code got=%b/%0d exp=1/4", err, code);
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        total++;
        if ({done, err, code, hold} !== 6'b100000) begin
            bad++;
            $display("FAIL empty_frame got=%b exp=100000", {done, err, code, hold});
        end
    endtask

    task automatic test_framing;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if ({err, code, busy, hold} !== 6'b100101) begin
            bad++;
            $display("FAIL framing_status got=%b exp=100101", {err, code, busy, hold});
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if ({busy, err, done} !== 3'b100) begin
            bad++;
            $display("FAIL glitch got=%b exp=100", {busy, err, done});
        end
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        total++;
        if ({done, hold} !== 2'b10) begin
            bad++;
            $display("FAIL after_glitch got=%b exp=10", {done, hold});
        end
    endtask

    task automatic test_reset_mid;
        int base;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h9A, 1'b1);
        total++;
        if ({busy, hold} !== 2'b11) begin
            bad++;
            $display("FAIL mid_busy got=%b exp=11", {busy, hold});
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({im_we, im_addr, im_wdata} !== 43'd0) begin
            bad++;
            $display("FAIL midrst_wport got=%b/%h/%h exp=0/0/0", im_we, im_addr, im_wdata);
        end
        total++;
        if ({hold, busy, done, err, code} !== 7'b1000000) begin
            bad++;
            $display("FAIL midrst_status got=%b exp=1000000", {hold, busy, done, err, code});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        base = wr_n;
        send_image(8'h00);
        check_two_writes(base, "reload");
        total++;
        if ({done, hold, err} !== 3'b100) begin
            bad++;
            $display("FAIL reload_status got=%b exp=100", {done, hold, err});
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        wr_n   = 0;
        we_out = 0;
        rst_n  = 1'b0;
        rx     = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_oversize();
        test_timeout();
        test_framing();
        test_reset_mid();
        total++;
        if (we_out !== 0) begin
            bad++;
            $display("FAIL we_outside_data got=%0d exp=0", we_out);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
